// File: rtl/fir_seq_pkg.sv
// FIR sequencer shared types: datapath opcodes, FSM states and
// register-map base addresses as functions of the tap count.
package fir_seq_pkg;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_COPY  = 3'd1,
      OP_LOAD1 = 3'd2,
      OP_LOAD2 = 3'd3,
      OP_ADD   = 3'd4,
      OP_SUB   = 3'd5,
      OP_MUL   = 3'd6
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOADC,
      ST_STORE,
      ST_SORT,
      ST_MUL,
      ST_ACC,
      ST_DONE,
      ST_EIDLE
   } state_t;

   // R0 accumulator, R1..RN window, R(N+1) sample, then coefficients, then products
   localparam int unsigned ACC_REG  = 0;
   localparam int unsigned WIN_BASE = 1;

   function automatic int unsigned sample_reg(input int unsigned n);
      return n + 1;
   endfunction

   function automatic int unsigned coef_base(input int unsigned n);
      return n + 2;
   endfunction

   function automatic int unsigned prod_base(input int unsigned n);
      return 2 * n + 2;
   endfunction

endpackage

// File: rtl/fir_sequencer_if.sv
// Sequencer <-> datapath control bus. master = sequencer, slave = datapath.
interface fir_sequencer_if
   import fir_seq_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 4
);
   logic                  data_ready;
   logic                  load_coeff;
   logic                  overflow;
   op_t                   op;
   logic [REG_ADDR_W-1:0] src1;
   logic [REG_ADDR_W-1:0] src2;
   logic [REG_ADDR_W-1:0] dest;
   logic                  modwait;
   logic                  cnt_up;
   logic                  err;

   modport master (
      input  data_ready, load_coeff, overflow,
      output op, src1, src2, dest, modwait, cnt_up, err
   );

   modport slave (
      output data_ready, load_coeff, overflow,
      input  op, src1, src2, dest, modwait, cnt_up, err
   );
endinterface

// File: rtl/fir_seq_tapcnt.sv
// Tap index counter used by the SORT, MUL and ACC phases of the sequencer.
module fir_seq_tapcnt #(
   parameter int unsigned NUM_TAPS = 4,
   parameter int unsigned W        = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] idx,
   output logic         tc
);
   // index advances while a phase repeats, returns to zero otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      idx <= '0;
      else if (clr) idx <= '0;
      else if (en)  idx <= idx + 1'b1;
   end

   // terminal count on the last tap of a phase
   always_comb tc = (idx == W'(NUM_TAPS - 1));
endmodule

// File: rtl/fir_sequencer.sv
// FIR datapath control FSM: coefficient load, sample store, window shift,
// per-tap multiply, accumulate with overflow check. Result left in R0.
// Optional: define FIR_SEQ_PENDING_EN for a one-deep pending sample.
module fir_sequencer
   import fir_seq_pkg::*;
#(
   parameter int unsigned NUM_TAPS   = 4,
   parameter int unsigned REG_ADDR_W = 4
) (
   input logic             clk,
   input logic             rst,
   fir_sequencer_if.master bus
);
   localparam int unsigned W = REG_ADDR_W;
   localparam logic [W-1:0] ACC_R  = W'(ACC_REG);
   localparam logic [W-1:0] WIN_R  = W'(WIN_BASE);
   localparam logic [W-1:0] SAMP_R = W'(sample_reg(NUM_TAPS));
   localparam logic [W-1:0] COEF_R = W'(coef_base(NUM_TAPS));
   localparam logic [W-1:0] PROD_R = W'(prod_base(NUM_TAPS));
   localparam logic [W-1:0] LAST   = W'(NUM_TAPS - 1);

   typedef struct packed {
      op_t          op;
      logic [W-1:0] src1;
      logic [W-1:0] src2;
      logic [W-1:0] dest;
      logic         modwait;
   } ctl_t;

   state_t       state, nxt_state;
   ctl_t         ctl_q;
   logic         cnt_up_q, err_q, pending;
   logic [W-1:0] cidx, idx, nidx;
   logic         tc, busy, loop_st, stay, dr_busy, lc_busy, chain;

   // control word for the cycle spent in state s at step index i
   function automatic ctl_t decode(input state_t s, input logic [W-1:0] i);
      ctl_t c;
      c.op      = OP_NOP;
      c.src1    = '0;
      c.src2    = '0;
      c.dest    = '0;
      c.modwait = 1'b1;
      case (s)
         ST_LOADC: begin c.op = OP_LOAD2; c.dest = COEF_R + i; end
         ST_STORE: begin c.op = OP_LOAD1; c.dest = SAMP_R; end
         ST_SORT:  begin c.op = OP_COPY; c.src1 = WIN_R + i + 1'b1; c.dest = WIN_R + i; end
         ST_MUL:   begin
            c.op = OP_MUL; c.src1 = WIN_R + i; c.src2 = COEF_R + i; c.dest = PROD_R + i;
         end
         ST_ACC:   begin
            c.dest = ACC_R;
            if (i == '0) begin c.op = OP_COPY; c.src1 = PROD_R; end
            else begin c.op = OP_ADD; c.src1 = ACC_R; c.src2 = PROD_R + i; end
         end
         ST_DONE:  c.op = OP_NOP;
         default:  c.modwait = 1'b0;
      endcase
      return c;
   endfunction

   fir_seq_tapcnt #(.NUM_TAPS(NUM_TAPS), .W(W)) u_tapcnt (
      .clk (clk),
      .rst (rst),
      .clr (!stay),
      .en  (stay),
      .idx (idx),
      .tc  (tc)
   );

   // next state and the step index that the next state will decode with
   always_comb begin
      busy    = !(state inside {ST_IDLE, ST_EIDLE});
      loop_st = state inside {ST_SORT, ST_MUL, ST_ACC};
      // a sample colliding with a coefficient strobe in idle is treated as busy
      dr_busy = bus.data_ready && (busy || bus.load_coeff);
      lc_busy = bus.load_coeff && busy;
`ifdef FIR_SEQ_PENDING_EN
      chain   = pending || bus.data_ready;
`else
      chain   = 1'b0;
`endif
      nxt_state = state;
      case (state)
         ST_IDLE, ST_EIDLE: begin
            if (bus.load_coeff)                   nxt_state = ST_LOADC;
            else if (bus.data_ready || pending)   nxt_state = ST_STORE;
         end
         ST_LOADC: nxt_state = ST_IDLE;
         ST_STORE: nxt_state = ST_SORT;
         ST_SORT:  if (tc) nxt_state = ST_MUL;
         ST_MUL:   if (tc) nxt_state = ST_ACC;
         ST_ACC: begin
            if (bus.overflow && idx != '0) nxt_state = ST_EIDLE;
            else if (tc)                   nxt_state = ST_DONE;
         end
         ST_DONE:  nxt_state = chain ? ST_STORE : ST_IDLE;
         default:  nxt_state = ST_IDLE;
      endcase
      stay = loop_st && (nxt_state == state);
      if (stay)                        nidx = idx + 1'b1;
      else if (nxt_state == ST_LOADC)  nidx = cidx;
      else                             nidx = '0;
   end

   // state, registered control word, coefficient index, pending and error flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         ctl_q.op      <= OP_NOP;
         ctl_q.src1    <= '0;
         ctl_q.src2    <= '0;
         ctl_q.dest    <= '0;
         ctl_q.modwait <= 1'b0;
         cnt_up_q      <= 1'b0;
         err_q         <= 1'b0;
         pending       <= 1'b0;
         cidx          <= '0;
      end else begin
         state    <= nxt_state;
         ctl_q    <= decode(nxt_state, nidx);
         cnt_up_q <= (nxt_state == ST_DONE);
         if (nxt_state == ST_LOADC) cidx <= (cidx == LAST) ? '0 : cidx + 1'b1;
         if (nxt_state == ST_STORE) err_q <= 1'b0;
         if (nxt_state == ST_EIDLE || lc_busy) err_q <= 1'b1;
`ifdef FIR_SEQ_PENDING_EN
         // entering STORE consumes the pended sample; a second one is lost
         if (nxt_state == ST_STORE) pending <= 1'b0;
         else if (dr_busy)          pending <= 1'b1;
         if (dr_busy && pending)    err_q   <= 1'b1;
`else
         pending <= 1'b0;
         if (dr_busy) err_q <= 1'b1;
`endif
      end
   end

   // drive the bus from the registered control word
   always_comb begin
      bus.op      = ctl_q.op;
      bus.src1    = ctl_q.src1;
      bus.src2    = ctl_q.src2;
      bus.dest    = ctl_q.dest;
      bus.modwait = ctl_q.modwait;
      bus.cnt_up  = cnt_up_q;
      bus.err     = err_q;
   end
endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer (NUM_TAPS=4, REG_ADDR_W=4).
// Build with or without FIR_SEQ_PENDING_EN; expectations follow the macro.
module tb_fir_sequencer
   import fir_seq_pkg::*;
;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [14:0] tr [1:14];

   fir_sequencer_if #(.REG_ADDR_W(4)) bif ();

   fir_sequencer #(.NUM_TAPS(4), .REG_ADDR_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   function automatic logic [14:0] pk(input op_t o, input int unsigned s1,
                                      input int unsigned s2, input int unsigned d);
      logic [3:0] a, b, c;
      a = 4'(s1); b = 4'(s2); c = 4'(d);
      return {o, a, b, c};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [14:0] bus_now();
      return {bif.op, bif.src1, bif.src2, bif.dest};
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      tr[1]  = pk(OP_LOAD1, 0, 0, 5);
      tr[2]  = pk(OP_COPY, 2, 0, 1);
      tr[3]  = pk(OP_COPY, 3, 0, 2);
      tr[4]  = pk(OP_COPY, 4, 0, 3);
      tr[5]  = pk(OP_COPY, 5, 0, 4);
      tr[6]  = pk(OP_MUL, 1, 6, 10);
      tr[7]  = pk(OP_MUL, 2, 7, 11);
      tr[8]  = pk(OP_MUL, 3, 8, 12);
      tr[9]  = pk(OP_MUL, 4, 9, 13);
      tr[10] = pk(OP_COPY, 10, 0, 0);
      tr[11] = pk(OP_ADD, 0, 11, 0);
      tr[12] = pk(OP_ADD, 0, 12, 0);
      tr[13] = pk(OP_ADD, 0, 13, 0);
      tr[14] = pk(OP_NOP, 0, 0, 0);

      rst = 1'b1;
      bif.data_ready = 1'b0;
      bif.load_coeff = 1'b0;
      bif.overflow   = 1'b0;
      ticks(3);
      rst = 1'b0;
      tick();

      // reset state
      chk("rst_bus", 32'(bus_now()), 32'(pk(OP_NOP, 0, 0, 0)));
      chk("rst_modwait", 32'(bif.modwait), 0);
      chk("rst_cnt_up", 32'(bif.cnt_up), 0);
      chk("rst_err", 32'(bif.err), 0);
      chk("rst_state", 32'(dut.state), 32'(ST_IDLE));

      // 1: reset in cycle 7 (MUL)
      bif.data_ready = 1'b1; tick(); bif.data_ready = 1'b0;
      ticks(6);
      chk("t1_c7_mul", 32'(bus_now()), 32'(pk(OP_MUL, 2, 7, 11)));
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t1_rst_bus", 32'(bus_now()), 32'(pk(OP_NOP, 0, 0, 0)));
      chk("t1_rst_modwait", 32'(bif.modwait), 0);
      chk("t1_rst_cnt_up", 32'(bif.cnt_up), 0);
      chk("t1_rst_state", 32'(dut.state), 32'(ST_IDLE));
      bif.data_ready = 1'b1; tick(); bif.data_ready = 1'b0;
      ticks(12);
      chk("t1_c13_cnt_up", 32'(bif.cnt_up), 0);
      tick();
      chk("t1_c14_cnt_up", 32'(bif.cnt_up), 1);
      tick();

      // 2: coefficient loads, fifth wraps to dest 6
      for (int p = 0; p < 5; p++) begin
         bif.load_coeff = 1'b1; tick(); bif.load_coeff = 1'b0;
         chk($sformatf("t2_load%0d_bus", p), 32'(bus_now()),
             32'(pk(OP_LOAD2, 0, 0, (p == 4) ? 6 : 6 + p)));
         chk($sformatf("t2_load%0d_mw", p), 32'(bif.modwait), 1);
         tick();
         chk($sformatf("t2_idle%0d_mw", p), 32'(bif.modwait), 0);
         tick();
      end

      // 3: full sample trace
      bif.data_ready = 1'b1; tick(); bif.data_ready = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         chk($sformatf("t3_c%0d_bus", c), 32'(bus_now()), 32'(tr[c]));
         chk($sformatf("t3_c%0d_mw", c), 32'(bif.modwait), 1);
         chk($sformatf("t3_c%0d_cnt_up", c), 32'(bif.cnt_up), (c == 14) ? 1 : 0);
         if (c < 14) tick();
      end
      tick();
      chk("t3_c15_mw", 32'(bif.modwait), 0);
      chk("t3_c15_bus", 32'(bus_now()), 32'(pk(OP_NOP, 0, 0, 0)));

      // 4: overflow on second ADD
      bif.data_ready = 1'b1; tick(); bif.data_ready = 1'b0;
      ticks(11);
      chk("t4_c12_bus", 32'(bus_now()), 32'(pk(OP_ADD, 0, 12, 0)));
      bif.overflow = 1'b1; tick(); bif.overflow = 1'b0;
      chk("t4_c13_err", 32'(bif.err), 1);
      chk("t4_c13_mw", 32'(bif.modwait), 0);
      chk("t4_c13_bus", 32'(bus_now()), 32'(pk(OP_NOP, 0, 0, 0)));
      chk("t4_c13_state", 32'(dut.state), 32'(ST_EIDLE));
      for (int c = 14; c <= 16; c++) begin
         tick();
         chk($sformatf("t4_c%0d_cnt_up", c), 32'(bif.cnt_up), 0);
      end
      bif.data_ready = 1'b1; tick(); bif.data_ready = 1'b0;
      chk("t4_store_err", 32'(bif.err), 0);
      chk("t4_store_bus", 32'(bus_now()), 32'(pk(OP_LOAD1, 0, 0, 5)));
      ticks(14);

      // 5: data_ready while busy in cycle 5
      bif.data_ready = 1'b1; tick(); bif.data_ready = 1'b0;
      ticks(4);
      bif.data_ready = 1'b1; tick(); bif.data_ready = 1'b0;
      ticks(8);
      chk("t5_c14_cnt_up", 32'(bif.cnt_up), 1);
      tick();
`ifdef FIR_SEQ_PENDING_EN
      chk("t5_c15_bus", 32'(bus_now()), 32'(pk(OP_LOAD1, 0, 0, 5)));
      chk("t5_c15_err", 32'(bif.err), 0);
      ticks(13);
      chk("t5_c28_cnt_up", 32'(bif.cnt_up), 1);
      tick();
`else
      chk("t5_c15_bus", 32'(bus_now()), 32'(pk(OP_NOP, 0, 0, 0)));
      chk("t5_c15_err", 32'(bif.err), 1);
      chk("t5_c15_mw", 32'(bif.modwait), 0);
`endif

      // 6: data_ready and load_coeff together in idle
      bif.data_ready = 1'b1; bif.load_coeff = 1'b1; tick();
      bif.data_ready = 1'b0; bif.load_coeff = 1'b0;
      chk("t6_c1_bus", 32'(bus_now()), 32'(pk(OP_LOAD2, 0, 0, 7)));
      chk("t6_c1_mw", 32'(bif.modwait), 1);
      tick();
      chk("t6_c2_bus", 32'(bus_now()), 32'(pk(OP_NOP, 0, 0, 0)));
      tick();
`ifdef FIR_SEQ_PENDING_EN
      chk("t6_c3_bus", 32'(bus_now()), 32'(pk(OP_LOAD1, 0, 0, 5)));
      ticks(13);
      chk("t6_c16_cnt_up", 32'(bif.cnt_up), 1);
      tick();
`else
      chk("t6_c3_bus", 32'(bus_now()), 32'(pk(OP_NOP, 0, 0, 0)));
      chk("t6_c3_mw", 32'(bif.modwait), 0);
`endif

      // 7: load_coeff while busy is ignored and sets a sticky err
      bif.data_ready = 1'b1; tick(); bif.data_ready = 1'b0;
      ticks(2);
      bif.load_coeff = 1'b1; tick(); bif.load_coeff = 1'b0;
      chk("t7_c4_err", 32'(bif.err), 1);
      chk("t7_c4_bus", 32'(bus_now()), 32'(pk(OP_COPY, 4, 0, 3)));
      ticks(10);
      chk("t7_c14_cnt_up", 32'(bif.cnt_up), 1);
      tick();
      chk("t7_c15_err", 32'(bif.err), 1);
      bif.load_coeff = 1'b1; tick(); bif.load_coeff = 1'b0;
      chk("t7_loadc_bus", 32'(bus_now()), 32'(pk(OP_LOAD2, 0, 0, 8)));
      ticks(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fir_sequencer.md
Name: fir_sequencer

Overview:
- Control FSM for the FIR filter datapath (shared ALU + 16-entry register file, op/src1/src2/dest interface).
- Sequences the per-sample steps: store, window shift, per-tap multiply, accumulate, overflow check.
- Also sequences coefficient loading.
- Leaves the signed result in R0; the downstream magnitude stage converts R0 to a 16-bit unsigned output.

Parameters:
- NUM_TAPS, 4, filter taps (2..4); must satisfy 3*NUM_TAPS+2 <= 2**REG_ADDR_W.
- REG_ADDR_W, 4, register-file address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_ready  in  1  one-cycle strobe: new sample present on datapath input.
- load_coeff  in  1  one-cycle strobe: next coefficient present on datapath input.
- overflow  in  1  ALU overflow, combinationally valid during ADD op cycle.
- op  out  3  datapath opcode (fir_seq_pkg::op_t).
- src1  out  REG_ADDR_W  source register 1.
- src2  out  REG_ADDR_W  source register 2.
- dest  out  REG_ADDR_W  destination register.
- modwait  out  1  high while a sample or coefficient is being processed.
- cnt_up  out  1  one-cycle pulse: sample result valid in R0.
- err  out  1  error flag.

Behaviour:
- Register map (N=NUM_TAPS): R0 accumulator; R1..RN window (R1 oldest); R(N+1) sample; R(N+2)..R(2N+1) coefficients; R(2N+2)..R(3N+1) products.
- Reset: state IDLE, tap/coeff counters 0, pending 0. Outputs op=NOP, src1=src2=dest=0, modwait=0, cnt_up=0, err=0.
- All outputs are registered; each decoded value appears in the cycle the state is occupied.
- IDLE: NOP.
  - load_coeff -> LOADC (takes priority).
  - Otherwise data_ready -> STORE.
- LOADC (1 cycle): op=LOAD2, dest=R(N+2+cidx). cidx increments, wrapping at N. Returns to IDLE. modwait=1.
- STORE (1 cycle): op=LOAD1, dest=R(N+1). Clears err.
- SORT (N cycles, i=0..N-1): op=COPY, src1=R(i+2), dest=R(i+1).
- MUL (N cycles): op=MUL, src1=R(1+i), src2=R(N+2+i), dest=R(2N+2+i).
- ACC (N cycles):
  - i=0: op=COPY, src1=R(2N+2), dest=R0.
  - i>0: op=ADD, src1=R0, src2=R(2N+2+i), dest=R0.
  - overflow=1 at the clock edge ending any ADD cycle -> EIDLE.
- DONE (1 cycle): cnt_up=1. Then STORE if pending (pending cleared), else IDLE.
- EIDLE: err=1, modwait=0, NOP.
  - data_ready -> STORE.
  - load_coeff -> LOADC; err stays 1 until the next STORE.
- Latency: data_ready sampled at edge 0 -> STORE in cycle 1, DONE/cnt_up in cycle 3N+2 (14 for N=4).
- modwait is high from cycle 1 through DONE inclusive.
- data_ready while busy (STORE..DONE or LOADC): see Optional Feature.
- load_coeff while busy: ignored, err set to 1 (sticky until next STORE).
- data_ready before all N coefficients are loaded: processed normally; result uses the stale coefficient registers.
- Reset asserted mid-sequence: immediate return to reset state. Partial register-file contents are not cleaned up.

Optional Feature:
- Macro FIR_SEQ_PENDING_EN.
- Defined: one-deep pending flag.
  - data_ready while busy sets pending.
  - DONE then chains directly to STORE.
  - A second data_ready while pending=1 sets err=1; the extra sample is dropped.
- Undefined: any data_ready while busy is dropped and sets err=1. DONE always returns to IDLE.

Decomposition:
- Package fir_seq_pkg:
  - op_t enum: NOP=0, COPY=1, LOAD1=2, LOAD2=3, ADD=4, SUB=5, MUL=6.
  - state_t enum: IDLE, LOADC, STORE, SORT, MUL, ACC, DONE, EIDLE.
  - Register-map base functions of NUM_TAPS.
- Sub-module fir_seq_tapcnt: tap index counter (clear, enable, terminal-count at NUM_TAPS-1). The FSM uses it in SORT, MUL and ACC.

Test Plan:
1. Reset mid-MUL (rst pulsed in cycle 7) -> all outputs 0 next cycle, state IDLE; a fresh data_ready gives cnt_up 14 cycles later.
2. Four load_coeff pulses, 3 cycles apart -> LOAD2 issued with dest 6,7,8,9, modwait high one cycle each; a fifth pulse writes dest 6 (wrap).
3. data_ready from IDLE, overflow=0 -> exact op/src/dest trace: LOAD1 d5; COPY 2->1..5->4; MUL 1*6->10 .. 4*9->13; COPY 10->0; ADD 0+11..0+13 -> 0. cnt_up in cycle 14 only; modwait cycles 1-14.
4. overflow=1 during the second ADD (cycle 12) -> EIDLE in cycle 13, err=1, cnt_up never pulses; the next data_ready clears err in the STORE cycle.
5. data_ready in cycle 5 with FIR_SEQ_PENDING_EN -> DONE (cycle 14) followed by STORE in cycle 15, cnt_up again in cycle 28. Without the macro -> err=1, IDLE in cycle 15.
6. data_ready and load_coeff in the same IDLE cycle -> LOADC first; the data_ready is dropped (or pended under FIR_SEQ_PENDING_EN, then processed).
